// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: geometry defaults, CPU op codes, FSM states.
// Latency: none (declarations and one pure address-packing function).
// Backpressure: none.
package vram_pkg;

    localparam int HPOS_W = 7;
    localparam int VPOS_W = 6;
    localparam int PIX_W  = 2;
    localparam int ADDR_W = HPOS_W + VPOS_W;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_XOR   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRB   = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Row-major VRAM address: row in the upper bits, column in the lower bits.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [VPOS_W-1:0] vpos,
                                                    input logic [HPOS_W-1:0] hpos);
        return {vpos, hpos};
    endfunction

endpackage

// File: rtl/vram_clear_sweep.sv
// Address sweep for the CLEAR op; present only when VRAM_ARB_CLEAR_EN is defined.
// Latency: count advances one step per cycle with advance high; last is combinational.
// Backpressure: advance low (display owns the port) freezes the count in place.
`ifdef VRAM_ARB_CLEAR_EN
module vram_clear_sweep #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // The counter wraps back to 0 after the final address, leaving it ready for the next sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    assign last = &count;

endmodule
`endif

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout reads vs. CHIP-8 CPU READ/WRITE/XOR/CLEAR (CLEAR sweep needs VRAM_ARB_CLEAR_EN).
// Latency accept->ack: WRITE 2, READ 3, XOR 4, CLEAR 8193 (1 without the sweep), plus 1 per display-stalled port cycle.
// Backpressure: disp_req always wins the port; CPU holds cpu_req until cpu_ack, no timeout.
module vram_arbiter #(
    parameter int HPOS_W = vram_pkg::HPOS_W,
    parameter int VPOS_W = vram_pkg::VPOS_W,
    parameter int PIX_W  = vram_pkg::PIX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_req,
    input  logic [HPOS_W-1:0]        disp_hpos,
    input  logic [VPOS_W-1:0]        disp_vpos,
    output logic [PIX_W-1:0]         disp_pixel,
    input  logic                     cpu_req,
    input  logic [1:0]               cpu_op,
    input  logic [HPOS_W-1:0]        cpu_hpos,
    input  logic [VPOS_W-1:0]        cpu_vpos,
    input  logic [PIX_W-1:0]         cpu_wdata,
    output logic                     cpu_ack,
    output logic [PIX_W-1:0]         cpu_rdata,
    output logic                     cpu_collide,
    output logic                     busy,
    output logic [VPOS_W+HPOS_W-1:0] mem_addr,
    output logic                     mem_we,
    output logic [PIX_W-1:0]         mem_wdata,
    input  logic [PIX_W-1:0]         mem_rdata
);
    import vram_pkg::*;

    localparam int AW = HPOS_W + VPOS_W;

    state_t            state;
    logic [1:0]        op_q;
    logic [AW-1:0]     addr_q;
    logic [PIX_W-1:0]  wdata_q;
    logic              disp_q;

`ifdef VRAM_ARB_CLEAR_EN
    logic [AW-1:0]     sweep_cnt;
    logic              sweep_last;
    logic              sweep_adv;

    assign sweep_adv = (state == ST_CLEAR) && !disp_req;

    vram_clear_sweep #(
        .CNT_W   (AW)
    ) u_sweep (
        .clk     (clk),
        .reset   (reset),
        .advance (sweep_adv),
        .count   (sweep_cnt),
        .last    (sweep_last)
    );
`endif

    assign busy = (state != ST_IDLE);

    // Display read data arrives one cycle after its address; capture it in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q     <= 1'b0;
            disp_pixel <= '0;
        end else begin
            disp_q <= disp_req;
            if (disp_q) begin
                disp_pixel <= mem_rdata;
            end
        end
    end

    // CPU sequencer: accept, wait out display cycles, use the port, pulse ack on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_collide <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Acceptance never touches memory, so it proceeds even during display cycles.
                    if (cpu_req) begin
                        op_q        <= cpu_op;
                        addr_q      <= {cpu_vpos, cpu_hpos};
                        wdata_q     <= cpu_wdata;
                        cpu_rdata   <= '0;
                        cpu_collide <= 1'b0;
                        if (cpu_op == OP_CLEAR) begin
`ifdef VRAM_ARB_CLEAR_EN
                            state   <= ST_CLEAR;
`else
                            state   <= ST_DONE;
                            cpu_ack <= 1'b1;
`endif
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!disp_req) begin
                        if (op_q == OP_WRITE) begin
                            state   <= ST_DONE;
                            cpu_ack <= 1'b1;
                        end else begin
                            state <= ST_CAPT;
                        end
                    end
                end
                ST_CAPT: begin
                    // Read data belongs to the ISSUE address even if the display grabs the port now.
                    cpu_rdata   <= mem_rdata;
                    cpu_collide <= (op_q == OP_XOR) && (|(mem_rdata & wdata_q));
                    if (op_q == OP_XOR) begin
                        state <= ST_WRB;
                    end else begin
                        state   <= ST_DONE;
                        cpu_ack <= 1'b1;
                    end
                end
                ST_WRB: begin
                    if (!disp_req) begin
                        state   <= ST_DONE;
                        cpu_ack <= 1'b1;
                    end
                end
                ST_CLEAR: begin
`ifdef VRAM_ARB_CLEAR_EN
                    if (!disp_req && sweep_last) begin
                        state   <= ST_DONE;
                        cpu_ack <= 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Port mux: display first, then whatever the CPU state needs; gated during reset so an abort writes nothing.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (disp_req) begin
            mem_addr = {disp_vpos, disp_hpos};
        end else if (!reset) begin
            case (state)
                ST_ISSUE: begin
                    mem_we = (op_q == OP_WRITE);
                end
                ST_WRB: begin
                    mem_we    = 1'b1;
                    mem_wdata = cpu_rdata ^ wdata_q;
                end
`ifdef VRAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    mem_addr  = sweep_cnt;
                    mem_we    = 1'b1;
                    mem_wdata = '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: write-first RAM model, shadow-memory reference, slot-based latency model.
// Latency: n/a.
// Backpressure: display request patterns are driven per op to exercise stalls.
module tb_vram_arbiter;
    import vram_pkg::*;

`ifdef VRAM_ARB_CLEAR_EN
    localparam int         CLR_LAT      = 8193;
    localparam logic [1:0] RD_AFTER_CLR = 2'd0;
`else
    localparam int         CLR_LAT      = 1;
    localparam logic [1:0] RD_AFTER_CLR = 2'd3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [6:0]  disp_hpos;
    logic [5:0]  disp_vpos;
    logic [1:0]  disp_pixel;
    logic        cpu_req;
    logic [1:0]  cpu_op;
    logic [6:0]  cpu_hpos;
    logic [5:0]  cpu_vpos;
    logic [1:0]  cpu_wdata;
    logic        cpu_ack;
    logic [1:0]  cpu_rdata;
    logic        cpu_collide;
    logic        busy;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_hpos   (disp_hpos),
        .disp_vpos   (disp_vpos),
        .disp_pixel  (disp_pixel),
        .cpu_req     (cpu_req),
        .cpu_op      (cpu_op),
        .cpu_hpos    (cpu_hpos),
        .cpu_vpos    (cpu_vpos),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_collide (cpu_collide),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Write-first synchronous RAM with a backdoor port for preloading.
    logic [1:0]  vram [0:8191];
    logic        bk_we;
    logic [12:0] bk_addr;
    logic [1:0]  bk_dat;

    always @(posedge clk) begin
        if (bk_we) begin
            vram[bk_addr] <= bk_dat;
        end else if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
            mem_rdata      <= mem_wdata;
        end else begin
            mem_rdata <= vram[mem_addr];
        end
    end

    // Reference memory contents as the CPU ops should leave them.
    logic [1:0] sh [0:8191];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic disp_at(input int n, input logic [63:0] dpat, input int bs, input int bl);
        logic in_pat;
        in_pat = 1'b0;
        if (n >= 0 && n < 64) in_pat = dpat[n];
        return in_pat | (n >= bs && n < bs + bl);
    endfunction

    function automatic int next_free(input int t, input logic [63:0] dpat, input int bs, input int bl);
        int u;
        u = t;
        while (disp_at(u, dpat, bs, bl)) u++;
        return u;
    endfunction

    // Each op needs a set of port slots; a slot is the first cycle the display leaves free.
    function automatic int model_lat(input logic [1:0] op, input logic [63:0] dpat, input int bs, input int bl);
        int t1;
        int t2;
        case (op)
            OP_WRITE: return next_free(1, dpat, bs, bl) + 1;
            OP_READ:  return next_free(1, dpat, bs, bl) + 2;
            OP_XOR: begin
                t1 = next_free(1, dpat, bs, bl);
                t2 = next_free(t1 + 2, dpat, bs, bl);
                return t2 + 1;
            end
            default: begin
`ifdef VRAM_ARB_CLEAR_EN
                t1 = 1;
                for (int k = 0; k < 8192; k++) t1 = next_free(t1, dpat, bs, bl) + 1;
                return t1;
`else
                return 1;
`endif
            end
        endcase
    endfunction

    task automatic model_apply(input logic [1:0] op, input int h, input int v, input logic [1:0] w,
                               output logic [1:0] rd, output logic col);
        int a;
        a = v * 128 + h;
        rd = 2'd0;
        col = 1'b0;
        case (op)
            OP_WRITE: sh[a] = w;
            OP_READ:  rd = sh[a];
            OP_XOR: begin
                rd = sh[a];
                col = (sh[a] & w) != 2'd0;
                sh[a] = sh[a] ^ w;
            end
            default: begin
`ifdef VRAM_ARB_CLEAR_EN
                for (int i = 0; i < 8192; i++) sh[i] = 2'd0;
`endif
            end
        endcase
    endtask

    // Starts in an IDLE cycle; returns in the IDLE cycle after DONE. Checks display pixels along the way.
    task automatic do_op(input logic [1:0] op, input int h, input int v, input logic [1:0] w,
                         input logic [63:0] dpat, input int bs, input int bl,
                         output int lat, output logic [1:0] rd, output logic col);
        logic       v1, v2, d;
        logic [1:0] e1, e2;
        lat = -1; rd = 2'd0; col = 1'b0;
        v1 = 1'b0; v2 = 1'b0; e1 = 2'd0; e2 = 2'd0;
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_hpos  = 7'(h);
        cpu_vpos  = 6'(v);
        cpu_wdata = w;
        for (int n = 0; n <= 20000; n++) begin
            if (n > 0 && cpu_ack) begin
                lat = n;
                rd  = cpu_rdata;
                col = cpu_collide;
                break;
            end
            if (v2) chk("disp_pixel_lag", int'(disp_pixel), int'(e2));
            v2 = v1;
            e2 = e1;
            d = disp_at(n, dpat, bs, bl);
            disp_req  = d;
            disp_hpos = 7'($urandom);
            disp_vpos = 6'($urandom);
            v1 = d;
            e1 = vram[pack_addr(disp_vpos, disp_hpos)];
            @(posedge clk); #1;
        end
        cpu_req  = 1'b0;
        disp_req = 1'b0;
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL ack_timeout: got no ack required one within 20000 cycles");
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        int          h;
        int          v;
        logic [1:0]  w;
        logic [63:0] dpat;
        int          lat;
        logic        chk_rd;
        logic [1:0]  rd;
        logic        col;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int         lat;
        int         exp_lat;
        int         bad;
        logic [1:0] rd, erd;
        logic       col, ecol;
        logic [1:0] op;
        int         h, v;
        logic [1:0] w;
        logic [63:0] dpat;
        logic [1:0] ep [1:5];

        tbl[0]  = '{OP_WRITE, 10, 5, 2'd3, 64'h0,  2,       1'b0, 2'd0, 1'b0};
        tbl[1]  = '{OP_READ,  10, 5, 2'd0, 64'h0,  3,       1'b1, 2'd3, 1'b0};
        tbl[2]  = '{OP_XOR,   10, 5, 2'd1, 64'h0,  4,       1'b1, 2'd3, 1'b1};
        tbl[3]  = '{OP_READ,  10, 5, 2'd0, 64'h0,  3,       1'b1, 2'd2, 1'b0};
        tbl[4]  = '{OP_XOR,   10, 5, 2'd1, 64'h0,  4,       1'b1, 2'd2, 1'b0};
        tbl[5]  = '{OP_READ,  10, 5, 2'd0, 64'h0,  3,       1'b1, 2'd3, 1'b0};
        tbl[6]  = '{OP_WRITE, 127, 63, 2'd2, 64'h6, 4,      1'b0, 2'd0, 1'b0};
        tbl[7]  = '{OP_READ,  127, 63, 2'd0, 64'h2, 4,      1'b1, 2'd2, 1'b0};
        tbl[8]  = '{OP_WRITE, 0,  0, 2'd1, 64'h0,  2,       1'b0, 2'd0, 1'b0};
        tbl[9]  = '{OP_XOR,   0,  0, 2'd3, 64'hA,  5,       1'b1, 2'd1, 1'b1};
        tbl[10] = '{OP_CLEAR, 0,  0, 2'd0, 64'h0,  CLR_LAT, 1'b1, 2'd0, 1'b0};
        tbl[11] = '{OP_READ,  10, 5, 2'd0, 64'h0,  3,       1'b1, RD_AFTER_CLR, 1'b0};

        reset = 1'b1; disp_req = 1'b0; disp_hpos = '0; disp_vpos = '0;
        cpu_req = 1'b0; cpu_op = '0; cpu_hpos = '0; cpu_vpos = '0; cpu_wdata = '0;
        bk_we = 1'b0; bk_addr = '0; bk_dat = '0;

        // Preload random contents while reset is held.
        @(posedge clk); #1;
        bk_we = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            bk_addr = 13'(i);
            bk_dat  = 2'($urandom);
            sh[i]   = bk_dat;
            @(posedge clk); #1;
        end
        bk_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(cpu_ack), 0);
        chk("rst_rdata", int'(cpu_rdata), 0);
        chk("rst_collide", int'(cpu_collide), 0);
        chk("rst_disp_pixel", int'(disp_pixel), 0);
        chk("rst_mem_we", int'(mem_we), 0);

        // Table-driven directed ops.
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].h, tbl[i].v, tbl[i].w, tbl[i].dpat, 0, 0, lat, rd, col);
            model_apply(tbl[i].op, tbl[i].h, tbl[i].v, tbl[i].w, erd, ecol);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            if (tbl[i].chk_rd) begin
                chk($sformatf("tbl%0d_rdata", i), int'(rd), int'(tbl[i].rd));
                chk($sformatf("tbl%0d_collide", i), int'(col), int'(tbl[i].col));
            end
        end

        // WRITE held off by five display cycles, then display read-after-write of the same pixel.
        cpu_req = 1'b1; cpu_op = OP_WRITE; cpu_hpos = 7'd20; cpu_vpos = 6'd7; cpu_wdata = 2'd1;
        disp_req = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            disp_req = 1'b1; disp_hpos = 7'(k); disp_vpos = 6'd2;
            ep[k] = vram[pack_addr(6'd2, 7'(k))];
            #1;
            chk($sformatf("stall%0d_mem_we", k), int'(mem_we), 0);
            chk($sformatf("stall%0d_ack", k), int'(cpu_ack), 0);
            if (k >= 3) chk($sformatf("stall%0d_disp_pixel", k), int'(disp_pixel), int'(ep[k-2]));
            @(posedge clk); #1;
        end
        disp_req = 1'b0;
        #1;
        chk("stall_write_we", int'(mem_we), 1);
        chk("stall_write_addr", int'(mem_addr), int'(pack_addr(6'd7, 7'd20)));
        chk("stall_disp_pixel4", int'(disp_pixel), int'(ep[4]));
        @(posedge clk); #1;
        chk("stall_ack_lat7", int'(cpu_ack), 1);
        chk("stall_disp_pixel5", int'(disp_pixel), int'(ep[5]));
        cpu_req = 1'b0;
        disp_req = 1'b1; disp_hpos = 7'd20; disp_vpos = 6'd7;
        sh[pack_addr(6'd7, 7'd20)] = 2'd1;
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(posedge clk); #1;
        chk("raw_disp_pixel", int'(disp_pixel), 1);

        // Reset landing on a display-stalled write-back of an XOR.
        cpu_req = 1'b1; cpu_op = OP_XOR; cpu_hpos = 7'd30; cpu_vpos = 6'd9; cpu_wdata = 2'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        disp_req = 1'b1; reset = 1'b1;
        #1;
        chk("abort_mem_we", int'(mem_we), 0);
        @(posedge clk); #1;
        reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdata", int'(cpu_rdata), 0);
        chk("abort_disp_pixel", int'(disp_pixel), 0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_ack", int'(cpu_ack), 0);
            chk("abort_no_write", int'(mem_we), 0);
            @(posedge clk); #1;
        end
        chk("abort_mem_kept", int'(vram[pack_addr(6'd9, 7'd30)]), int'(sh[pack_addr(6'd9, 7'd30)]));
        do_op(OP_READ, 30, 9, 2'd0, 64'h0, 0, 0, lat, rd, col);
        model_apply(OP_READ, 30, 9, 2'd0, erd, ecol);
        chk("abort_read_lat", lat, 3);
        chk("abort_read_rdata", int'(rd), int'(erd));

`ifdef VRAM_ARB_CLEAR_EN
        // CLEAR with a 100-cycle display burst in the middle of the sweep.
        do_op(OP_CLEAR, 0, 0, 2'd0, 64'h0, 500, 100, lat, rd, col);
        model_apply(OP_CLEAR, 0, 0, 2'd0, erd, ecol);
        chk("clear_burst_lat", lat, 8293);
        chk("clear_burst_model_lat", lat, model_lat(OP_CLEAR, 64'h0, 500, 100));
        bad = 0;
        for (int i = 0; i < 8192; i++) if (vram[i] !== 2'd0) bad++;
        chk("clear_all_zero", bad, 0);
`endif

        // Randomised ops against the shadow memory and slot latency model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(2, 0));
`ifndef VRAM_ARB_CLEAR_EN
            if ($urandom_range(7, 0) == 0) op = OP_CLEAR;
`endif
            h = ($urandom_range(1, 0) == 1) ? int'($urandom_range(3, 0)) : int'($urandom_range(127, 124));
            v = ($urandom_range(1, 0) == 1) ? int'($urandom_range(1, 0)) : int'($urandom_range(63, 62));
            w = 2'($urandom);
            dpat = {$urandom, $urandom} & {$urandom, $urandom};
            exp_lat = model_lat(op, dpat, 0, 0);
            model_apply(op, h, v, w, erd, ecol);
            do_op(op, h, v, w, dpat, 0, 0, lat, rd, col);
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat);
            if (op != OP_WRITE) chk($sformatf("rnd%0d_rdata", i), int'(rd), int'(erd));
            if (op != OP_WRITE) chk($sformatf("rnd%0d_collide", i), int'(col), int'(ecol));
        end

        bad = 0;
        for (int i = 0; i < 8192; i++) if (vram[i] !== sh[i]) bad++;
        chk("final_mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no summary required one before time limit");
        $fatal(1, "watchdog");
    end

endmodule
